// File: rtl/axis_arb_pkg.sv
// Shared types and the round-robin search helper for axis_cmd_arbiter.
// rr_pick works on a fixed-width request vector so any NUM_SLAVES up to RR_MAX can use it.
package axis_arb_pkg;

   localparam int RR_MAX   = 32;
   localparam int RR_IDX_W = 5;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic                found;
      logic [RR_IDX_W-1:0] idx;
   } rr_pick_t;

   // First set bit of valid[0 +: n], searching upward from ptr and wrapping at n.
   function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]   valid,
                                        input logic [RR_IDX_W-1:0] ptr,
                                        input int                  n);
      rr_pick_t res;
      int       j;
      res = '0;
      for (int i = 0; i < RR_MAX; i++) begin
         if (i < n) begin
            j = int'(ptr) + i;
            if (j >= n) j = j - n;
            if (!res.found && valid[j]) begin
               res.found = 1'b1;
               res.idx   = j[RR_IDX_W-1:0];
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry registered AXI-Stream output stage; out_free_o says a new beat may load.
module axis_out_reg
   import axis_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 8,
   parameter int DEST_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [ID_WIDTH-1:0]   id_i,
   input  logic [DEST_WIDTH-1:0] dest_i,
   input  logic                  last_i,
   output logic                  out_free_o,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic [DATA_WIDTH-1:0] m_data_o,
   output logic [ID_WIDTH-1:0]   m_id_o,
   output logic [DEST_WIDTH-1:0] m_dest_o,
   output logic                  m_last_o
);

   logic                  valid_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic [DEST_WIDTH-1:0] dest_q;
   logic                  last_q;

   assign out_free_o = !valid_q || m_ready_i;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         id_q    <= '0;
         dest_q  <= '0;
         last_q  <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
         id_q    <= id_i;
         dest_q  <= dest_i;
         last_q  <= last_i;
      end else if (out_free_o) begin
         valid_q <= 1'b0;
      end
   end

   assign m_valid_o = valid_q;
   assign m_data_o  = data_q;
   assign m_id_o    = id_q;
   assign m_dest_o  = dest_q;
   assign m_last_o  = last_q;

endmodule

// File: rtl/axis_cmd_arbiter.sv
// Packet-level round-robin merge of NUM_SLAVES AXI-Stream command sources.
// Define AXIS_ARB_ID_STAMP_EN to replace m_id with the granted source index.
//
// state      | meaning
// ARB_IDLE   | no packet owns the output; round-robin search from rr_ptr
// ARB_LOCKED | source sel owns the output until its last beat is accepted
module axis_cmd_arbiter
   import axis_arb_pkg::*;
#(
   parameter int NUM_SLAVES = 4,
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 8,
   parameter int DEST_WIDTH = 8
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic [NUM_SLAVES-1:0]            s_valid,
   output logic [NUM_SLAVES-1:0]            s_ready,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_data,
   input  logic [NUM_SLAVES*ID_WIDTH-1:0]   s_id,
   input  logic [NUM_SLAVES*DEST_WIDTH-1:0] s_dest,
   input  logic [NUM_SLAVES-1:0]            s_last,
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic [DATA_WIDTH-1:0]            m_data,
   output logic [ID_WIDTH-1:0]              m_id,
   output logic [DEST_WIDTH-1:0]            m_dest,
   output logic                             m_last
);

   localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   arb_state_t        state_q, state_d;
   logic [IDX_W-1:0]  sel_q, sel_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]  grant_idx;
   rr_pick_t          pick;
   logic              grant_vld;
   logic              out_free;
   logic              accept;
   logic              grant_last;
   logic [ID_WIDTH-1:0] grant_id;
   logic              unused_pick;

   function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
      return (int'(i) == NUM_SLAVES - 1) ? '0 : i + 1'b1;
   endfunction

   assign pick        = rr_pick(RR_MAX'(s_valid), RR_IDX_W'(rr_ptr_q), NUM_SLAVES);
   assign unused_pick = ^pick.idx;
   assign grant_idx   = (state_q == ARB_LOCKED) ? sel_q : pick.idx[IDX_W-1:0];
   assign grant_vld   = (state_q == ARB_LOCKED) || pick.found;
   assign grant_last  = s_last[grant_idx];
   assign accept      = |(s_valid & s_ready);

   // Gated by rstn so no source sees a handshake while reset is asserted.
   always_comb begin
      s_ready = '0;
      if (rstn && grant_vld && out_free) s_ready[grant_idx] = 1'b1;
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         if (grant_last) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = inc_idx(grant_idx);
         end else begin
            state_d  = ARB_LOCKED;
            sel_d    = grant_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= ARB_IDLE;
         sel_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

`ifdef AXIS_ARB_ID_STAMP_EN
   logic unused_s_id;
   if (ID_WIDTH < IDX_W) begin : g_id_width_chk
      $error("axis_cmd_arbiter: ID_WIDTH too narrow to hold the source index");
   end
   assign unused_s_id = ^s_id;
   assign grant_id    = ID_WIDTH'(grant_idx);
`else
   assign grant_id    = s_id[grant_idx*ID_WIDTH +: ID_WIDTH];
`endif

   axis_out_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .ID_WIDTH   (ID_WIDTH),
      .DEST_WIDTH (DEST_WIDTH)
   ) u_out_reg (
      .clk        (clk),
      .rstn       (rstn),
      .load_i     (accept),
      .data_i     (s_data[grant_idx*DATA_WIDTH +: DATA_WIDTH]),
      .id_i       (grant_id),
      .dest_i     (s_dest[grant_idx*DEST_WIDTH +: DEST_WIDTH]),
      .last_i     (grant_last),
      .out_free_o (out_free),
      .m_valid_o  (m_valid),
      .m_ready_i  (m_ready),
      .m_data_o   (m_data),
      .m_id_o     (m_id),
      .m_dest_o   (m_dest),
      .m_last_o   (m_last)
   );

endmodule

// File: tb/tb_axis_cmd_arbiter.sv
// Scoreboard bench for axis_cmd_arbiter (N=4 main instance, N=3 instance for index wrap).
module tb_axis_cmd_arbiter;

   localparam int N  = 4;
   localparam int DW = 64;
   localparam int IW = 8;
   localparam int TW = 8;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [IW-1:0] id;
      logic [TW-1:0] dest;
      logic          last;
   } beat_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]    s_valid, s_ready, s_last;
   logic [N*DW-1:0] s_data;
   logic [N*IW-1:0] s_id;
   logic [N*TW-1:0] s_dest;
   logic            m_valid, m_ready, m_last;
   logic [DW-1:0]   m_data;
   logic [IW-1:0]   m_id;
   logic [TW-1:0]   m_dest;

   logic [2:0]      s_valid3, s_ready3, s_last3;
   logic [3*DW-1:0] s_data3;
   logic [3*IW-1:0] s_id3;
   logic [3*TW-1:0] s_dest3;
   logic            m_valid3, m_ready3, m_last3;
   logic [DW-1:0]   m_data3;
   logic [IW-1:0]   m_id3;
   logic [TW-1:0]   m_dest3;

   axis_cmd_arbiter #(.NUM_SLAVES(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(TW)) u_dut (
      .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_id(s_id), .s_dest(s_dest), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_id(m_id), .m_dest(m_dest), .m_last(m_last));

   axis_cmd_arbiter #(.NUM_SLAVES(3), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(TW)) u_dut3 (
      .clk(clk), .rstn(rstn), .s_valid(s_valid3), .s_ready(s_ready3), .s_data(s_data3),
      .s_id(s_id3), .s_dest(s_dest3), .s_last(s_last3), .m_valid(m_valid3), .m_ready(m_ready3),
      .m_data(m_data3), .m_id(m_id3), .m_dest(m_dest3), .m_last(m_last3));

   beat_t    srcq[N][$];
   beat_t    exp_q[$];
   beat_t    mon_e;
   int       tests = 0;
   int       fails = 0;
   int       ncyc = 0;
   int       first_hs = -1;
   int       first_out = -1;
   int       last_out = -1;
   int       out_cnt = 0;
   logic     lock_watch = 1'b0;
   logic [N-1:0] hs_seen = '0;
   logic [DW-1:0] hold_data;
   logic [IW-1:0] hold_id;
   logic          hold_last;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      if (obs !== expv) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
      end
   endtask

   // data = {src, pkt, beat}; dest carries the source so a stamped id can be predicted
   function automatic beat_t mk_beat(input int src, input int pkt, input int b, input bit last);
      beat_t r;
      r.data = (64'(src) << 16) | (64'(pkt) << 8) | 64'(b);
      r.id   = 8'h10 + 8'(src);
      r.dest = 8'h20 + 8'(src);
      r.last = last;
      return r;
   endfunction

   function automatic logic [IW-1:0] exp_id(input beat_t e);
`ifdef AXIS_ARB_ID_STAMP_EN
      return e.dest - 8'h20;
`else
      return e.id;
`endif
   endfunction

   task automatic add_pkt(input int src, input int pkt, input int nb);
      for (int b = 1; b <= nb; b++) srcq[src].push_back(mk_beat(src, pkt, b, b == nb));
   endtask

   task automatic expect_pkt(input int src, input int pkt, input int nb);
      for (int b = 1; b <= nb; b++) exp_q.push_back(mk_beat(src, pkt, b, b == nb));
   endtask

   task automatic drive();
      s_valid = '0;
      s_last  = '0;
      for (int i = 0; i < N; i++) begin
         if (srcq[i].size() > 0) begin
            s_valid[i]            = 1'b1;
            s_last[i]             = srcq[i][0].last;
            s_data[i*DW +: DW]    = srcq[i][0].data;
            s_id[i*IW +: IW]      = srcq[i][0].id;
            s_dest[i*TW +: TW]    = srcq[i][0].dest;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
         if (hs_seen[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      drive();
   endtask

   task automatic wait_drain(input string tag, input int limit);
      int k = 0;
      while (exp_q.size() > 0 && k < limit) begin
         tick();
         k++;
      end
      chk(tag, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic run_lock(input string tag, input int limit);
      int k = 0;
      while (exp_q.size() > 0 && k < limit) begin
         tick();
         lock_watch = (srcq[1].size() > 0) && (srcq[1].size() < 4);
         k++;
      end
      lock_watch = 1'b0;
      chk(tag, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      for (int i = 0; i < N; i++) srcq[i].delete();
      exp_q.delete();
      drive();
      repeat (2) tick();
      rstn = 1'b1;
   endtask

   always @(negedge clk) begin
      ncyc++;
      hs_seen = s_valid & s_ready;
      if (hs_seen != '0 && first_hs < 0) first_hs = ncyc;
      if (lock_watch) chk("lock_s_ready0", 64'(s_ready[0]), 64'd0);
      if (rstn && m_valid && m_ready) begin
         mon_e = '0;
         if (exp_q.size() > 0) mon_e = exp_q.pop_front();
         chk("beat_data", m_data, mon_e.data);
         chk("beat_id", 64'(m_id), 64'(exp_id(mon_e)));
         chk("beat_dest", 64'(m_dest), 64'(mon_e.dest));
         chk("beat_last", 64'(m_last), 64'(mon_e.last));
         if (first_out < 0) first_out = ncyc;
         last_out = ncyc;
         out_cnt++;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      s_valid = '0; s_last = '0; s_data = '0; s_id = '0; s_dest = '0; m_ready = 1'b1;
      s_valid3 = '0; s_last3 = '0; s_data3 = '0; s_id3 = '0; s_dest3 = '0; m_ready3 = 1'b1;

      // reset values, with all sources requesting
      rstn = 1'b0;
      s_valid = '1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_m_data", m_data, 64'd0);
      chk("rst_m_id", 64'(m_id), 64'd0);
      chk("rst_m_dest", 64'(m_dest), 64'd0);
      chk("rst_m_last", 64'(m_last), 64'd0);
      chk("rst_s_ready", 64'(s_ready), 64'd0);
      chk("rst_m_valid3", 64'(m_valid3), 64'd0);
      s_valid = '0;
      rstn = 1'b1;

      // wrap on N=3: move rr_ptr to 2, then sources 1 and 2 compete
      s_last3  = 3'b111;
      s_data3  = {64'd3, 64'd2, 64'd1};
      s_valid3 = 3'b001;
      @(negedge clk); chk("wrap_grant_s0", 64'(s_ready3), 64'd1);
      @(posedge clk); #1; s_valid3 = 3'b010;
      @(negedge clk); chk("wrap_grant_s1a", 64'(s_ready3), 64'd2);
      @(posedge clk); #1; s_valid3 = 3'b110;
      @(negedge clk); chk("wrap_grant_s2", 64'(s_ready3), 64'd4);
      @(posedge clk); #1;
      @(negedge clk); chk("wrap_grant_s1b", 64'(s_ready3), 64'd2);
      chk("wrap_out_s2", m_data3, 64'd3);
      @(posedge clk); #1; s_valid3 = '0;
      @(negedge clk); chk("wrap_out_s1", m_data3, 64'd2);

      // single 3-beat packet from source 2, then rr_ptr must sit at 3
      do_reset();
      first_hs = -1; first_out = -1;
      add_pkt(2, 1, 3); expect_pkt(2, 1, 3); drive();
      wait_drain("drain_single", 50);
      chk("latency", 64'(first_out - first_hs), 64'd1);
      add_pkt(0, 2, 1); add_pkt(3, 2, 1);
      expect_pkt(3, 2, 1); expect_pkt(0, 2, 1); drive();
      wait_drain("drain_ptr3", 50);

      // round robin over single-beat packets, no bubbles
      do_reset();
      out_cnt = 0; first_out = -1;
      for (int p = 0; p < 4; p++)
         for (int s = 0; s < N; s++) begin
            add_pkt(s, 10 + p, 1);
            expect_pkt(s, 10 + p, 1);
         end
      drive();
      wait_drain("drain_rr", 100);
      chk("rr_count", 64'(out_cnt), 64'd16);
      chk("rr_span", 64'(last_out - first_out + 1), 64'd16);

      // lock: source 1 holds the output while source 0 keeps requesting
      do_reset();
      add_pkt(0, 1, 1); expect_pkt(0, 1, 1); drive();
      wait_drain("drain_lock_pre", 50);
      add_pkt(1, 2, 4); add_pkt(0, 2, 1); add_pkt(0, 3, 1); add_pkt(2, 2, 1);
      expect_pkt(1, 2, 4); expect_pkt(2, 2, 1); expect_pkt(0, 2, 1); expect_pkt(0, 3, 1);
      drive();
      run_lock("drain_lock_a", 100);
      add_pkt(1, 4, 4); add_pkt(0, 4, 1);
      expect_pkt(1, 4, 4); expect_pkt(0, 4, 1);
      drive();
      run_lock("drain_lock_b", 100);

      // backpressure for 5 cycles mid-packet
      add_pkt(3, 5, 4); expect_pkt(3, 5, 4); drive();
      k = 0;
      while (!m_valid && k < 20) begin tick(); k++; end
      chk("bp_valid_seen", 64'(m_valid), 64'd1);
      m_ready = 1'b0;
      hold_data = m_data; hold_id = m_id; hold_last = m_last;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         chk("bp_data", m_data, hold_data);
         chk("bp_id", 64'(m_id), 64'(hold_id));
         chk("bp_last", 64'(m_last), 64'(hold_last));
         chk("bp_valid", 64'(m_valid), 64'd1);
         chk("bp_s_ready", 64'(s_ready), 64'd0);
         tick();
      end
      m_ready = 1'b1;
      wait_drain("drain_bp", 50);

      // reset after beat 2 of 4 from source 3, with rr_ptr at 2 beforehand
      add_pkt(1, 6, 1); expect_pkt(1, 6, 1); drive();
      wait_drain("drain_rm_pre", 50);
      add_pkt(3, 6, 4); exp_q.push_back(mk_beat(3, 6, 1, 1'b0)); drive();
      k = 0;
      while (srcq[3].size() > 2 && k < 20) begin tick(); k++; end
      rstn = 1'b0;
      @(negedge clk);
      chk("rm_s_ready_in_rst", 64'(s_ready), 64'd0);
      chk("rm_beat1_out", 64'(exp_q.size()), 64'd0);
      @(posedge clk); #1;
      chk("rm_m_valid", 64'(m_valid), 64'd0);
      chk("rm_m_data", m_data, 64'd0);
      chk("rm_s_ready", 64'(s_ready), 64'd0);
      for (int i = 0; i < N; i++) srcq[i].delete();
      exp_q.delete();
      rstn = 1'b1;
      add_pkt(3, 7, 1); add_pkt(2, 7, 1); add_pkt(0, 7, 1);
      expect_pkt(0, 7, 1); expect_pkt(2, 7, 1); expect_pkt(3, 7, 1);
      drive();
      wait_drain("drain_rm_post", 50);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
